// File: rtl/matrix_pkg.sv
// Shared types for the 8x8 LED matrix driver, its scan capture block and benches.
package matrix_pkg;

  localparam int MATRIX_COLS = 8;
  localparam int MATRIX_ROWS = 8;

  typedef logic [2:0]  col_idx_t;
  typedef logic [7:0]  row_t;
  typedef logic [63:0] frame_t;

  typedef enum logic {
    HUNT  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  typedef struct packed {
    row_t     rows;
    col_idx_t col;
  } scan_sample_t;

  // Returns f with column c (bits 8*c+7 .. 8*c) replaced by r.
  function automatic frame_t put_col(input frame_t f, input col_idx_t c, input row_t r);
    frame_t res;
    res = f;
    res[{c, 3'b000} +: MATRIX_ROWS] = r;
    return res;
  endfunction

endpackage

// File: rtl/matrix_scan_capture_if.sv
// Scan bus from the display driver plus the rebuilt-frame outputs of the capture block.
interface matrix_scan_capture_if;

  logic                  rows_unused_guard;
  logic [7:0]            rows;
  matrix_pkg::col_idx_t  col_sel;
  matrix_pkg::frame_t    frame;
  logic                  frame_valid;
  logic [7:0]            frame_count;
  logic                  sync_err;
  logic                  stale;

  assign rows_unused_guard = 1'b0;

  modport master (
    output rows, col_sel,
    input  frame, frame_valid, frame_count, sync_err, stale
  );

  modport slave (
    input  rows, col_sel,
    output frame, frame_valid, frame_count, sync_err, stale
  );

endinterface

// File: rtl/scan_settle.sv
// Two-flop synchronizer plus settle filter: emits one accept strobe per new stable {rows, col}.
module scan_settle
  import matrix_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic     clk,
    input  logic     resetbutton,
    input  row_t     rows_i,
    input  col_idx_t col_i,
    output row_t     rows_o,
    output col_idx_t col_o,
    output logic     accept_o
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

    scan_sample_t sync1_q, sync2_q, prev_q, held_q;
    logic         held_vld_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          changed, fire;
    logic          accept_q;

    // NOTE: every combinational output gets a default before any branch so no latch can be inferred.
    always_comb begin
        changed = (sync2_q != prev_q);
        cnt_d   = cnt_q;
        if (changed)                cnt_d = CW'(1);
        else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CW'(1);
        // A value that bounces away and back (a glitch) must not be taken twice.
        fire = (cnt_d == CNT_MAX) && (changed || (cnt_q != CNT_MAX)) &&
               (!held_vld_q || (sync2_q != held_q));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            cnt_q      <= '0;
            accept_q   <= 1'b0;
        end else begin
            sync1_q  <= '{rows: rows_i, col: col_i};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            accept_q <= fire;
            if (fire) begin
                held_q     <= sync2_q;
                held_vld_q <= 1'b1;
            end
        end
    end

    assign rows_o   = held_q.rows;
    assign col_o    = held_q.col;
    assign accept_o = accept_q;

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds 8x8 frames from the multiplexed LED scan bus and flags out-of-order columns.
// Optional watchdog: define MATRIX_CAPTURE_STALE_EN.
module matrix_scan_capture
  import matrix_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int STALE_LIMIT   = 1024
) (
    input  logic                  clk,
    input  logic                  resetbutton,
    matrix_scan_capture_if.slave  bus
);

    logic     acc;
    row_t     acc_rows;
    col_idx_t acc_col;

    scan_settle #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk         (clk),
        .resetbutton (resetbutton),
        .rows_i      (bus.rows),
        .col_i       (bus.col_sel),
        .rows_o      (acc_rows),
        .col_o       (acc_col),
        .accept_o    (acc)
    );

    state_e   state_q, state_d;
    col_idx_t expected_q, expected_d;
    frame_t   shadow_q, shadow_d;
    frame_t   frame_q, frame_d;
    logic     frame_valid_q, frame_valid_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic     sync_err_q, sync_err_d;
    logic     stale_trip;
    logic     stale_o;

`ifdef MATRIX_CAPTURE_STALE_EN
    localparam int SW = $clog2(STALE_LIMIT + 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_LIMIT);

    logic [SW-1:0] stale_cnt_q, stale_cnt_d;
    logic          stale_q;

    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (acc)                          stale_cnt_d = '0;
        else if (stale_cnt_q != STALE_MAX) stale_cnt_d = stale_cnt_q + SW'(1);
        stale_trip = (stale_cnt_d == STALE_MAX) && (stale_cnt_q != STALE_MAX);
    end

    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
            if (acc)             stale_q <= 1'b0;
            else if (stale_trip) stale_q <= 1'b1;
        end
    end

    assign stale_o = stale_q;
`else
    assign stale_trip = 1'b0;
    // Without the watchdog the limit has no meaning; this expression is constant 0.
    assign stale_o    = (STALE_LIMIT < 0);
`endif

    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        sync_err_d    = 1'b0;

        if (acc) begin
            unique case (state_q)
                HUNT: begin
                    if (acc_col == 3'd0) begin
                        shadow_d   = put_col('0, 3'd0, acc_rows);
                        expected_d = 3'd1;
                        state_d    = SWEEP;
                    end
                end
                SWEEP: begin
                    if (acc_col == expected_q) begin
                        if (acc_col == 3'd7) begin
                            frame_d       = put_col(shadow_q, 3'd7, acc_rows);
                            frame_valid_d = 1'b1;
                            frame_count_d = frame_count_q + 8'd1;
                            shadow_d      = '0;
                            state_d       = HUNT;
                        end else begin
                            shadow_d   = put_col(shadow_q, acc_col, acc_rows);
                            expected_d = expected_q + 3'd1;
                        end
                    end else begin
                        sync_err_d = 1'b1;
                        // An early column 0 is treated as the start of a fresh sweep.
                        if (acc_col == 3'd0) begin
                            shadow_d   = put_col('0, 3'd0, acc_rows);
                            expected_d = 3'd1;
                        end else begin
                            shadow_d = '0;
                            state_d  = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (stale_trip) begin
            shadow_d = '0;
            state_d  = HUNT;
        end
    end

    // NOTE: the shadow buffer is reset because a reset must discard any partial sweep.
    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            state_q       <= HUNT;
            expected_q    <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.stale       = stale_o;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture: sweeps, wrap, ordering errors, glitch, reset, watchdog.
module tb_matrix_scan_capture;
  import matrix_pkg::*;

  localparam int SETTLE = 2;
  localparam int STALE  = 16;

  localparam frame_t F_ONEHOT  = 64'h8040201008040201;
  localparam frame_t F_ONECOLD = 64'h7FBFDFEFF7FBFDFE;
  localparam frame_t F_NIBBLE  = 64'h7766554433221100;

  logic clk = 1'b0;
  logic resetbutton;

  matrix_scan_capture_if bus ();

  matrix_scan_capture #(
    .SETTLE_CYCLES (SETTLE),
    .STALE_LIMIT   (STALE)
  ) dut (
    .clk         (clk),
    .resetbutton (resetbutton),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_pulses = 0;
  int err_pulses = 0;
  int v_run = 0, e_run = 0, v_max = 0, e_max = 0;
  bit both_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) valid_pulses++;
    if (bus.sync_err === 1'b1) err_pulses++;
    if (bus.frame_valid === 1'b1 && bus.sync_err === 1'b1) both_seen = 1'b1;
    v_run = (bus.frame_valid === 1'b1) ? v_run + 1 : 0;
    e_run = (bus.sync_err === 1'b1) ? e_run + 1 : 0;
    if (v_run > v_max) v_max = v_run;
    if (e_run > e_max) e_max = e_run;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] pat(input int mode, input int c);
    case (mode)
      0:       return 8'h01 << c;
      1:       return ~(8'h01 << c);
      default: return 8'(c * 17);
    endcase
  endfunction

  task automatic drive(input col_idx_t c, input logic [7:0] r, input int hold);
    bus.col_sel = c;
    bus.rows    = r;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int mode);
    for (int c = 0; c < 8; c++) drive(col_idx_t'(c), pat(mode, c), 4);
    idle(6);
  endtask

  task automatic do_reset();
    bus.rows    = 8'h00;
    bus.col_sel = 3'd7;
    resetbutton = 1'b0;
    idle(2);
    resetbutton = 1'b1;
    idle(6);
  endtask

  task automatic test_reset();
    bus.rows    = 8'h00;
    bus.col_sel = 3'd7;
    resetbutton = 1'b0;
    idle(3);
    if (bus.frame !== 64'd0) begin errors++; $display("FAIL reset_frame got %h want 0", bus.frame); end
    checks++;
    if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.frame_valid); end
    checks++;
    if (bus.frame_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.frame_count); end
    checks++;
    if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", bus.sync_err); end
    checks++;
    if (bus.stale !== 1'b0) begin errors++; $display("FAIL reset_stale got %b want 0", bus.stale); end
    checks++;
    resetbutton = 1'b1;
    idle(6);
    if (bus.frame !== 64'd0 || bus.frame_count !== 8'd0) begin
      errors++; $display("FAIL post_reset_idle frame %h count %0d want 0 0", bus.frame, bus.frame_count);
    end
    checks++;
  endtask

  task automatic test_single_sweep();
    int v0, e0;
    logic exp_v;
    v0 = valid_pulses; e0 = err_pulses;
    for (int c = 0; c < 7; c++) drive(col_idx_t'(c), pat(0, c), 4);
    bus.col_sel = 3'd7;
    bus.rows    = 8'h80;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      exp_v = (i == 3 + SETTLE);
      if (bus.frame_valid !== exp_v) begin
        errors++; $display("FAIL latency_valid edge %0d got %b want %b", i, bus.frame_valid, exp_v);
      end
      checks++;
    end
    idle(2);
    if (bus.frame !== F_ONEHOT) begin errors++; $display("FAIL single_frame got %h want %h", bus.frame, F_ONEHOT); end
    checks++;
    if (bus.frame_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", bus.frame_count); end
    checks++;
    if (valid_pulses - v0 !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", valid_pulses - v0); end
    checks++;
    if (err_pulses - e0 !== 0) begin errors++; $display("FAIL single_sync_err got %0d want 0", err_pulses - e0); end
    checks++;
  endtask

  task automatic test_out_of_order();
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    drive(3'd0, pat(1, 0), 4);
    drive(3'd1, pat(1, 1), 4);
    drive(3'd2, pat(1, 2), 4);
    drive(3'd5, pat(1, 5), 4);
    idle(6);
    if (err_pulses - e0 !== 1) begin errors++; $display("FAIL ooo_sync_err got %0d want 1", err_pulses - e0); end
    checks++;
    if (valid_pulses - v0 !== 0) begin errors++; $display("FAIL ooo_valid got %0d want 0", valid_pulses - v0); end
    checks++;
    if (bus.frame !== F_ONEHOT) begin errors++; $display("FAIL ooo_frame_held got %h want %h", bus.frame, F_ONEHOT); end
    checks++;
    sweep(1);
    if (bus.frame !== F_ONECOLD) begin errors++; $display("FAIL ooo_recover_frame got %h want %h", bus.frame, F_ONECOLD); end
    checks++;
    if (bus.frame_count !== 8'd2) begin errors++; $display("FAIL ooo_recover_count got %0d want 2", bus.frame_count); end
    checks++;
    if (valid_pulses - v0 !== 1 || err_pulses - e0 !== 1) begin
      errors++; $display("FAIL ooo_recover_pulses valid %0d err %0d want 1 1", valid_pulses - v0, err_pulses - e0);
    end
    checks++;
  endtask

  task automatic test_restart();
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    for (int c = 0; c < 3; c++) drive(col_idx_t'(c), pat(0, c), 4);
    sweep(0);
    if (err_pulses - e0 !== 1) begin errors++; $display("FAIL restart_sync_err got %0d want 1", err_pulses - e0); end
    checks++;
    if (valid_pulses - v0 !== 1) begin errors++; $display("FAIL restart_valid got %0d want 1", valid_pulses - v0); end
    checks++;
    if (bus.frame !== F_ONEHOT) begin errors++; $display("FAIL restart_frame got %h want %h", bus.frame, F_ONEHOT); end
    checks++;
    if (bus.frame_count !== 8'd3) begin errors++; $display("FAIL restart_count got %0d want 3", bus.frame_count); end
    checks++;
  endtask

  task automatic test_reaccept();
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    drive(3'd0, 8'h01, 4);
    drive(3'd1, 8'h11, 4);
    drive(3'd1, 8'h22, 4);
    idle(6);
    if (err_pulses - e0 !== 1) begin errors++; $display("FAIL reaccept_sync_err got %0d want 1", err_pulses - e0); end
    checks++;
    if (valid_pulses - v0 !== 0) begin errors++; $display("FAIL reaccept_valid got %0d want 0", valid_pulses - v0); end
    checks++;
    sweep(2);
    if (bus.frame !== F_NIBBLE) begin errors++; $display("FAIL reaccept_frame got %h want %h", bus.frame, F_NIBBLE); end
    checks++;
    if (bus.frame_count !== 8'd4) begin errors++; $display("FAIL reaccept_count got %0d want 4", bus.frame_count); end
    checks++;
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    drive(3'd0, 8'h01, 4);
    drive(3'd1, 8'h02, 2);
    drive(3'd3, 8'h02, 1);
    drive(3'd1, 8'h02, 3);
    for (int c = 2; c < 8; c++) drive(col_idx_t'(c), pat(0, c), 4);
    idle(6);
    if (err_pulses - e0 !== 0) begin errors++; $display("FAIL glitch_sync_err got %0d want 0", err_pulses - e0); end
    checks++;
    if (valid_pulses - v0 !== 1) begin errors++; $display("FAIL glitch_valid got %0d want 1", valid_pulses - v0); end
    checks++;
    if (bus.frame !== F_ONEHOT) begin errors++; $display("FAIL glitch_frame got %h want %h", bus.frame, F_ONEHOT); end
    checks++;
    if (bus.frame_count !== 8'd5) begin errors++; $display("FAIL glitch_count got %0d want 5", bus.frame_count); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    for (int c = 0; c < 4; c++) drive(col_idx_t'(c), pat(1, c), 4);
    bus.col_sel = 3'd4;
    bus.rows    = pat(1, 4);
    idle(2);
    #3;
    resetbutton = 1'b0;
    #1;
    if (bus.frame !== 64'd0) begin errors++; $display("FAIL midreset_frame got %h want 0", bus.frame); end
    checks++;
    if (bus.frame_count !== 8'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", bus.frame_count); end
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0 || bus.stale !== 1'b0) begin
      errors++; $display("FAIL midreset_flags valid %b err %b stale %b want 0 0 0", bus.frame_valid, bus.sync_err, bus.stale);
    end
    checks++;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetbutton = 1'b1;
    idle(6);
    v0 = valid_pulses; e0 = err_pulses;
    sweep(1);
    if (bus.frame_count !== 8'd1) begin errors++; $display("FAIL midreset_after_count got %0d want 1", bus.frame_count); end
    checks++;
    if (bus.frame !== F_ONECOLD) begin errors++; $display("FAIL midreset_after_frame got %h want %h", bus.frame, F_ONECOLD); end
    checks++;
    if (valid_pulses - v0 !== 1 || err_pulses - e0 !== 0) begin
      errors++; $display("FAIL midreset_after_pulses valid %0d err %0d want 1 0", valid_pulses - v0, err_pulses - e0);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int v0;
    do_reset();
    v0 = valid_pulses;
    for (int i = 0; i < 255; i++) sweep(0);
    if (bus.frame_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", bus.frame_count); end
    checks++;
    sweep(0);
    if (bus.frame_count !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", bus.frame_count); end
    checks++;
    if (valid_pulses - v0 !== 256) begin errors++; $display("FAIL wrap_pulses got %0d want 256", valid_pulses - v0); end
    checks++;
    if (bus.frame !== F_ONEHOT) begin errors++; $display("FAIL wrap_frame got %h want %h", bus.frame, F_ONEHOT); end
    checks++;
  endtask

`ifdef MATRIX_CAPTURE_STALE_EN
  task automatic test_stale();
    int v0, e0, n;
    v0 = valid_pulses; e0 = err_pulses;
    for (int c = 0; c < 4; c++) drive(col_idx_t'(c), pat(1, c), 4);
    if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_early got %b want 0", bus.stale); end
    checks++;
    n = 0;
    while (bus.stale !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.stale !== 1'b1) begin errors++; $display("FAIL stale_set got %b want 1", bus.stale); end
    checks++;
    if (n !== STALE + 1) begin errors++; $display("FAIL stale_delay got %0d edges want %0d", n, STALE + 1); end
    checks++;
    sweep(0);
    if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_clear got %b want 0", bus.stale); end
    checks++;
    if (bus.frame !== F_ONEHOT) begin errors++; $display("FAIL stale_frame got %h want %h", bus.frame, F_ONEHOT); end
    checks++;
    if (bus.frame_count !== 8'd1) begin errors++; $display("FAIL stale_count got %0d want 1", bus.frame_count); end
    checks++;
    if (valid_pulses - v0 !== 1 || err_pulses - e0 !== 0) begin
      errors++; $display("FAIL stale_pulses valid %0d err %0d want 1 0", valid_pulses - v0, err_pulses - e0);
    end
    checks++;
  endtask
`else
  task automatic test_stale();
    idle(40);
    if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_tied got %b want 0", bus.stale); end
    checks++;
  endtask
`endif

  task automatic test_pulse_shape();
    if (v_max !== 1) begin errors++; $display("FAIL valid_width got %0d want 1", v_max); end
    checks++;
    if (e_max !== 1) begin errors++; $display("FAIL sync_err_width got %0d want 1", e_max); end
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL valid_err_overlap got %b want 0", both_seen); end
    checks++;
  endtask

  initial begin
    resetbutton = 1'b0;
    bus.rows    = 8'h00;
    bus.col_sel = 3'd7;
    #1;
    test_reset();
    test_single_sweep();
    test_out_of_order();
    test_restart();
    test_reaccept();
    test_glitch();
    test_reset_mid();
    test_wrap();
    test_stale();
    test_pulse_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
